// File: rtl/johnson_decoder_checker.sv
// Johnson-code receiver and checker.
//   Samples a WIDTH-bit Johnson-coded bus on en, decodes it to a step index,
//   flags illegal codes and out-of-sequence jumps, tracks successor lock and
//   keeps a saturating count of errored samples.
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   en         sample strobe; q_in captured when high
//   q_in       Johnson-coded input
//   valid      one-cycle pulse, outputs below are from a fresh sample
//   idx        decoded step index (0 for illegal codes)
//   legal      sampled code is a legal Johnson code
//   seq_err    legal code that is neither the successor nor a repeat
//   locked     FSM is in the locked state after the current sample
//   err_count  saturating count of samples with !legal || seq_err
module johnson_decoder_checker #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned LOCK_N    = 4,
  parameter int unsigned ERR_CNT_W = 8,
  localparam int unsigned IDX_W    = $clog2(2 * WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     q_in,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx,
  output logic                 legal,
  output logic                 seq_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned GoodW = $clog2(LOCK_N + 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(2 * WIDTH - 1);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  // Reference Johnson code for step k: k ones filling from the LSB, then
  // (k-WIDTH) zeros filling from the LSB.
  function automatic logic [WIDTH-1:0] johnson_code(input int unsigned k);
    logic [WIDTH-1:0] code;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      code[b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
    end
    return code;
  endfunction

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       prev_idx_q, prev_idx_d;
  logic [GoodW-1:0]       good_q, good_d;
  logic                   valid_q, valid_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   legal_q, legal_d;
  logic                   seq_err_q, seq_err_d;
  logic                   locked_q, locked_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  logic                   dec_legal;
  logic [IDX_W-1:0]       dec_idx;
  logic [IDX_W-1:0]       succ_idx;
  logic [GoodW-1:0]       good_inc;
  logic                   is_succ;
  logic                   is_rep;

  // Decode: compare against every legal code; at most one can match.
  always_comb begin
    dec_legal = 1'b0;
    dec_idx   = '0;
    for (int unsigned k = 0; k < 2 * WIDTH; k++) begin
      if (q_in == johnson_code(k)) begin
        dec_legal = 1'b1;
        dec_idx   = IDX_W'(k);
      end
    end
  end

  assign succ_idx = (prev_idx_q == LastIdx) ? '0 : prev_idx_q + 1'b1;
  assign is_succ  = (dec_idx == succ_idx);
  assign is_rep   = (dec_idx == prev_idx_q);
  assign good_inc = good_q + 1'b1;

  // Next-state. The anchor (prev_idx) is only meaningful outside StSearch,
  // so StSearch itself serves as the "previous sample invalid" marker.
  always_comb begin
    state_d     = state_q;
    prev_idx_d  = prev_idx_q;
    good_d      = good_q;
    valid_d     = 1'b0;
    idx_d       = idx_q;
    legal_d     = legal_q;
    seq_err_d   = seq_err_q;
    err_count_d = err_count_q;

    if (en) begin
      valid_d   = 1'b1;
      idx_d     = dec_idx;
      legal_d   = dec_legal;
      seq_err_d = 1'b0;

      if (!dec_legal) begin
        state_d = StSearch;
        good_d  = '0;
      end else begin
        unique case (state_q)
          StSearch: begin
            state_d    = StTrack;
            good_d     = '0;
            prev_idx_d = dec_idx;
          end
          StTrack: begin
            if (is_succ) begin
              good_d     = good_inc;
              prev_idx_d = dec_idx;
              if (good_inc == GoodW'(LOCK_N)) state_d = StLocked;
            end else if (!is_rep) begin
              seq_err_d  = 1'b1;
              good_d     = '0;
              prev_idx_d = dec_idx;
            end
          end
          StLocked: begin
            prev_idx_d = dec_idx;
            if (!is_succ && !is_rep) begin
              seq_err_d = 1'b1;
              state_d   = StTrack;
              good_d    = '0;
            end
          end
          default: state_d = StSearch;
        endcase
      end

      if ((!dec_legal || seq_err_d) && (err_count_q != '1)) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  assign locked_d = (state_d == StLocked);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StSearch;
      prev_idx_q  <= '0;
      good_q      <= '0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      legal_q     <= 1'b0;
      seq_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_idx_q  <= prev_idx_d;
      good_q      <= good_d;
      valid_q     <= valid_d;
      idx_q       <= idx_d;
      legal_q     <= legal_d;
      seq_err_q   <= seq_err_d;
      locked_q    <= locked_d;
      err_count_q <= err_count_d;
    end
  end

  assign valid     = valid_q;
  assign idx       = idx_q;
  assign legal     = legal_q;
  assign seq_err   = seq_err_q;
  assign locked    = locked_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// Bench for johnson_decoder_checker: directed vector table for the default
// instance plus a hand sequence for saturation (ERR_CNT_W=2) and reset.
module tb_johnson_decoder_checker;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [4:0] q_in;

  logic       valid, legal, seq_err, locked;
  logic [3:0] idx;
  logic [7:0] err_count;

  logic       valid2, legal2, seq_err2, locked2;
  logic [3:0] idx2;
  logic [1:0] err_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  johnson_decoder_checker dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .q_in      (q_in),
    .valid     (valid),
    .idx       (idx),
    .legal     (legal),
    .seq_err   (seq_err),
    .locked    (locked),
    .err_count (err_count)
  );

  johnson_decoder_checker #(.ERR_CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .q_in      (q_in),
    .valid     (valid2),
    .idx       (idx2),
    .legal     (legal2),
    .seq_err   (seq_err2),
    .locked    (locked2),
    .err_count (err_count2)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [4:0] q;
    logic       valid;
    logic [3:0] idx;
    logic       legal;
    logic       seq_err;
    logic       locked;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic [4:0] q, logic v, logic [3:0] i,
                              logic l, logic s, logic lk, logic [7:0] ec);
    vec_t t;
    t.rst = r; t.en = e; t.q = q; t.valid = v; t.idx = i;
    t.legal = l; t.seq_err = s; t.locked = lk; t.err = ec;
    return t;
  endfunction

  task automatic check(input string name, input int n, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, n, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [4:0] q);
    @(negedge clk);
    rst  = r;
    en   = e;
    q_in = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; q_in = '0;

    // Reset holds everything at zero even with en=1.
    vecs.push_back(mk(1, 1, 5'b11111, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 5'b11111, 0, 0, 0, 0, 0, 0));
    // Steps 0..4: lock arrives with idx=4.
    vecs.push_back(mk(0, 1, 5'b00000, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5'b00001, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5'b00011, 1, 2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5'b00111, 1, 3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5'b01111, 1, 4, 1, 0, 1, 0));
    // Steps 5..9 then wrap to 0.
    vecs.push_back(mk(0, 1, 5'b11111, 1, 5, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 5'b11110, 1, 6, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 5'b11100, 1, 7, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 5'b11000, 1, 8, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 5'b10000, 1, 9, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 5'b00000, 1, 0, 1, 0, 1, 0));
    // Illegal drops lock; then anchor at 2 and jump to 4.
    vecs.push_back(mk(0, 1, 5'b00101, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 5'b00011, 1, 2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 5'b01111, 1, 4, 1, 1, 0, 2));
    // Successor, then en toggling with repeats: no error, outputs hold.
    vecs.push_back(mk(0, 1, 5'b11111, 1, 5, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 5'b11111, 0, 5, 1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 5'b11111, 1, 5, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 5'b11111, 0, 5, 1, 0, 0, 2));
    // Repeats did not advance good: lock only on the 4th successor (idx=8).
    vecs.push_back(mk(0, 1, 5'b11110, 1, 6, 1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 5'b11100, 1, 7, 1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 5'b11000, 1, 8, 1, 0, 1, 2));
    // Wrong legal code while locked: seq_err, back to tracking.
    vecs.push_back(mk(0, 1, 5'b00011, 1, 2, 1, 1, 0, 3));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].q);
      check("valid",     i, 32'(valid),     32'(vecs[i].valid));
      check("idx",       i, 32'(idx),       32'(vecs[i].idx));
      check("legal",     i, 32'(legal),     32'(vecs[i].legal));
      check("seq_err",   i, 32'(seq_err),   32'(vecs[i].seq_err));
      check("locked",    i, 32'(locked),    32'(vecs[i].locked));
      check("err_count", i, 32'(err_count), 32'(vecs[i].err));
    end

    // Saturation on the 2-bit counter instance.
    drive(1, 0, 5'b00000);
    check("rst_err2", 100, 32'(err_count2), 32'd0);
    begin
      logic [4:0] ill [5];
      ill[0] = 5'b00101; ill[1] = 5'b01010; ill[2] = 5'b10101;
      ill[3] = 5'b00100; ill[4] = 5'b01001;
      for (int k = 0; k < 5; k++) begin
        drive(0, 1, ill[k]);
        check("sat_err2", 101 + k, 32'(err_count2), (k < 3) ? 32'(k + 1) : 32'd3);
        check("wide_err", 101 + k, 32'(err_count), 32'(k + 1));
        check("ill_legal", 101 + k, 32'(legal2), 32'd0);
      end
    end

    // Re-lock, then reset mid-lock clears lock and counter on the next edge.
    begin
      logic [4:0] seq [5];
      seq[0] = 5'b00000; seq[1] = 5'b00001; seq[2] = 5'b00011;
      seq[3] = 5'b00111; seq[4] = 5'b01111;
      for (int k = 0; k < 5; k++) drive(0, 1, seq[k]);
    end
    check("relock", 110, 32'(locked2), 32'd1);
    check("relock_err2", 110, 32'(err_count2), 32'd3);
    drive(1, 1, 5'b11111);
    check("rst_locked2", 111, 32'(locked2), 32'd0);
    check("rst_err2b", 111, 32'(err_count2), 32'd0);
    check("rst_locked", 111, 32'(locked), 32'd0);
    check("rst_err", 111, 32'(err_count), 32'd0);
    check("rst_valid", 111, 32'(valid), 32'd0);
    // First legal sample after reset never errors.
    drive(0, 1, 5'b11000);
    check("post_rst_idx", 112, 32'(idx), 32'd8);
    check("post_rst_seq", 112, 32'(seq_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
